spi_crc_slave: RTL
==================

# spi_crc_slave

SPI slave endpoint on the far end of the SPI CRC master's link. It receives 72-bit frames (cmd, addr, data, CRC-8) on `mosi`, checks the CRC and presents the decoded fields to the local register side. On the next frame it returns the last accepted data word and its CRC on `miso`, which is the loopback the master reports as `spi_resp`. Single clock domain: `sclk`, `cs_n` and `mosi` are oversampled by `clk`.

## Interface
- `FRAME_BITS`, 72: total bits per frame (8 cmd + 24 addr + 32 data + 8 CRC); fixed, parameter exists for checking only.
- `CRC_POLY`, 8'h07: CRC-8 polynomial (x^8+x^2+x+1), init 8'h00, no reflection, no final XOR.

- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sclk` in 1: SPI clock, mode 0 (CPOL=0, CPHA=0), async to `clk`.
- `cs_n` in 1: active-low chip select, async.
- `mosi` in 1: serial data in, MSB first.
- `miso` out 1: serial data out, MSB first.
- `rx_valid` out 1: one-cycle pulse, frame ended (cs_n deasserted).
- `rx_cmd` out 8, `rx_addr` out 24, `rx_data` out 32: fields of the last frame; held until the next `rx_valid`.
- `crc_ok` out 1: qualifies the last frame; held until the next `rx_valid`.
- `frame_err` out 1: the last frame's bit count was not 72; held.
- `err_cnt` out 16: CRC/framing error count (only with the macro).

## Operation
- 2-flop synchronizers on `sclk`, `cs_n`, `mosi`. Edge detect happens on the synchronized copies plus one history flop.
- FSM states:
  - IDLE -> SHIFT on `cs_n` falling.
  - SHIFT -> CHECK on `cs_n` rising.
  - CHECK -> IDLE unconditionally, after one cycle.
- SHIFT behaviour:
  - Each `sclk` rising edge shifts `mosi` into a 72-bit shift register and increments a 7-bit bit counter, which saturates at 72.
  - Bits after the 72nd are ignored.
  - The CRC-8 is updated serially on bits 0..63 only.
- CHECK behaviour:
  - `frame_err` = (count != 72).
  - `crc_ok` = !frame_err && (computed CRC == received bits 64..71).
  - Fields load from the shift register and `rx_valid` pulses.
  - On `crc_ok`=1, the response register loads {rx_data, received CRC}.
  - Otherwise the response register is unchanged.
- MISO behaviour:
  - On `cs_n` falling, `miso` = response bit 39.
  - On each `sclk` falling edge the next bit is driven, for bits 39..0.
  - After 40 bits `miso` = 0. In IDLE, `miso` = 0.
- Reset values:
  - miso=0, rx_valid=0, rx_cmd/addr/data=0, crc_ok=0, frame_err=0, err_cnt=0.
  - Response register = 40'h0, FSM=IDLE.
- Reset mid-frame clears everything. The FSM stays in IDLE until it sees `cs_n` high, then low again; a frame already in progress is never accepted.
- A `cs_n` glitch high shorter than the synchronizer delay is not seen. A valid end of frame needs `cs_n` high for at least 2 `clk`.

## Timing
- `clk` must be at least 8x `sclk`. `sclk` high and low phases must each last at least 3 `clk`.
- Input sampling latency is 2 `clk` from pin to synchronized signal, plus 1 for edge detect.
- `rx_valid` is asserted 4 `clk` after the `cs_n` pin rises: 3 to detect the edge and 1 in CHECK.
- Fields, `crc_ok`, `frame_err` and `err_cnt` update in the same cycle as `rx_valid`.
- `miso` changes 3 `clk` after the `sclk` pin falls. The master samples on the rising edge, half an `sclk` period later.
- Back-to-back frames: `cs_n` may fall again 2 `clk` after CHECK. The response loaded in CHECK is used by that frame.

## Configuration
- `SPI_CRC_ERRCNT_EN` defined:
  - `err_cnt` is a 16-bit counter, incremented in CHECK when `crc_ok`=0 (CRC or framing error).
  - It saturates at 16'hFFFF and is cleared only by `rst`.
- Not defined: `err_cnt` is tied to 16'h0000 and no counter flops exist.

## Structure
- Shared package `spi_crc_pkg`:
  - CRC_POLY, FRAME_BITS, field widths (CMD_W=8, ADDR_W=24, DATA_W=32, CRC_W=8).
  - FSM state encoding.
  - The serial CRC-8 step function, shared with the master.
- One sub-module `spi_crc8_serial`: 1-bit/cycle CRC-8 with `clr`, `en` and `din` inputs, reused by the master.

## Test plan
- All-zero frame (cmd 00, addr 000000, data 00000000, crc 00) -> rx_valid 1 pulse, crc_ok=1, frame_err=0, fields all 0.
- cmd 00, addr 123456, data F0F0A5A5, crc from bench model -> crc_ok=1, rx_data=F0F0A5A5. The following frame returns F0F0A5A5 plus that crc on the first 40 `miso` bits.
- cmd FF, addr ABCDEF, data DEADBEEF, crc byte XOR 01 -> crc_ok=0, err_cnt 0->1 (with macro). The next frame's `miso` still returns F0F0A5A5.
- `cs_n` raised after 40 bits -> frame_err=1, crc_ok=0, response unchanged, err_cnt increments.
- 80 `sclk` pulses in one frame, valid first 72 bits -> crc_ok=1; extra bits ignored.
- `rst` pulsed at bit 30 of a frame -> all outputs 0, no rx_valid for that frame. The next full frame is accepted normally.

Source files
------------

// File: rtl/spi_crc_pkg.sv
// Shared definitions for the SPI CRC link: frame geometry, FSM encoding and
// the serial CRC-8 step used by both the slave and the master.
package spi_crc_pkg;

    localparam int CMD_W      = 8;
    localparam int ADDR_W     = 24;
    localparam int DATA_W     = 32;
    localparam int CRC_W      = 8;
    localparam int FRAME_BITS = CMD_W + ADDR_W + DATA_W + CRC_W;
    localparam int RESP_W     = DATA_W + CRC_W;
    localparam int CNT_W      = 7;
    localparam int ERRCNT_W   = 16;

    localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_e;

    // One MSB-first step of a non-reflected CRC with zero init and no final XOR.
    function automatic logic [CRC_W-1:0] crc8Step(input logic [CRC_W-1:0] crc,
                                                  input logic             din,
                                                  input logic [CRC_W-1:0] poly);
        logic fb;
        fb = crc[CRC_W-1] ^ din;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : {CRC_W{1'b0}});
    endfunction

endpackage

// File: rtl/spi_crc8_serial.sv
// Bit-serial CRC-8 engine: one bit per enabled clock, clr restarts from zero.
module spi_crc8_serial
    import spi_crc_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = 8'h07
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = crc8Step(crc_q, din, POLY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/spi_crc_slave.sv
// SPI mode-0 slave receiving CRC-8 protected 72-bit frames and looping back the
// last good data word plus CRC on miso. Optional error counter: SPI_CRC_ERRCNT_EN.
module spi_crc_slave
    import spi_crc_pkg::*;
#(
    parameter int               FRAME_BITS = 72,
    parameter logic [CRC_W-1:0] CRC_POLY   = 8'h07
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk,
    input  logic                cs_n,
    input  logic                mosi,
    output logic                miso,
    output logic                rx_valid,
    output logic [CMD_W-1:0]    rx_cmd,
    output logic [ADDR_W-1:0]   rx_addr,
    output logic [DATA_W-1:0]   rx_data,
    output logic                crc_ok,
    output logic                frame_err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] MSG_CNT  = CNT_W'(FRAME_BITS - CRC_W);

    logic [1:0] sclkSync_q, csSync_q, mosiSync_q;
    logic       sclkHist_q, csHist_q;

    // cs_n sync/history reset low so a frame already in progress never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclkSync_q <= '0;
            csSync_q   <= '0;
            mosiSync_q <= '0;
            sclkHist_q <= 1'b0;
            csHist_q   <= 1'b0;
        end else begin
            sclkSync_q <= {sclkSync_q[0], sclk};
            csSync_q   <= {csSync_q[0], cs_n};
            mosiSync_q <= {mosiSync_q[0], mosi};
            sclkHist_q <= sclkSync_q[1];
            csHist_q   <= csSync_q[1];
        end
    end

    logic sclkS, csS, mosiS;
    logic sclkRise, sclkFall, csRise, csFall;

    assign sclkS    = sclkSync_q[1];
    assign csS      = csSync_q[1];
    assign mosiS    = mosiSync_q[1];
    assign sclkRise = sclkS & ~sclkHist_q;
    assign sclkFall = ~sclkS & sclkHist_q;
    assign csRise   = csS & ~csHist_q;
    assign csFall   = ~csS & csHist_q;

    state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (csFall) state_d = SHIFT;
            SHIFT:   if (csRise) state_d = CHECK;
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    logic [FRAME_BITS-1:0] shiftReg_q, shiftReg_d;
    logic [CNT_W-1:0]      bitCnt_q, bitCnt_d;
    logic [RESP_W-1:0]     resp_q, resp_d;
    logic [RESP_W-1:0]     txReg_q, txReg_d;
    logic                  rxValid_q, rxValid_d;
    logic [CMD_W-1:0]      cmd_q, cmd_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  crcOk_q, crcOk_d;
    logic                  frameErr_q, frameErr_d;

    logic             startFrame, shiftEn, crcEn;
    logic [CRC_W-1:0] crcVal;
    logic             frameErrNow, crcOkNow;

    assign startFrame  = (state_q == IDLE) && csFall;
    assign shiftEn     = (state_q == SHIFT) && sclkRise && (bitCnt_q != FULL_CNT);
    assign crcEn       = shiftEn && (bitCnt_q < MSG_CNT);
    assign frameErrNow = (bitCnt_q != FULL_CNT);
    assign crcOkNow    = !frameErrNow && (crcVal == shiftReg_q[0 +: CRC_W]);

    spi_crc8_serial #(
        .POLY (CRC_POLY)
    ) u_crc (
        .clk  (clk),
        .rst  (rst),
        .clr  (startFrame),
        .en   (crcEn),
        .din  (mosiS),
        .crc  (crcVal)
    );

    // The loopback word is latched into txReg at frame start so a CHECK update mid-frame cannot tear it.
    always_comb begin
        shiftReg_d = shiftReg_q;
        bitCnt_d   = bitCnt_q;
        resp_d     = resp_q;
        txReg_d    = txReg_q;
        rxValid_d  = 1'b0;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        data_d     = data_q;
        crcOk_d    = crcOk_q;
        frameErr_d = frameErr_q;

        if (startFrame) begin
            shiftReg_d = '0;
            bitCnt_d   = '0;
            txReg_d    = resp_q;
        end

        if (shiftEn) begin
            shiftReg_d = {shiftReg_q[FRAME_BITS-2:0], mosiS};
            bitCnt_d   = bitCnt_q + CNT_W'(1);
        end

        if ((state_q == SHIFT) && sclkFall) begin
            txReg_d = {txReg_q[RESP_W-2:0], 1'b0};
        end

        if (state_q == CHECK) begin
            rxValid_d  = 1'b1;
            cmd_d      = shiftReg_q[CRC_W + DATA_W + ADDR_W +: CMD_W];
            addr_d     = shiftReg_q[CRC_W + DATA_W +: ADDR_W];
            data_d     = shiftReg_q[CRC_W +: DATA_W];
            crcOk_d    = crcOkNow;
            frameErr_d = frameErrNow;
            if (crcOkNow) begin
                resp_d = shiftReg_q[0 +: RESP_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shiftReg_q <= '0;
            bitCnt_q   <= '0;
            resp_q     <= '0;
            txReg_q    <= '0;
            rxValid_q  <= 1'b0;
            cmd_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            crcOk_q    <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            shiftReg_q <= shiftReg_d;
            bitCnt_q   <= bitCnt_d;
            resp_q     <= resp_d;
            txReg_q    <= txReg_d;
            rxValid_q  <= rxValid_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            crcOk_q    <= crcOk_d;
            frameErr_q <= frameErr_d;
        end
    end

    assign miso      = (state_q == SHIFT) & txReg_q[RESP_W-1];
    assign rx_valid  = rxValid_q;
    assign rx_cmd    = cmd_q;
    assign rx_addr   = addr_q;
    assign rx_data   = data_q;
    assign crc_ok    = crcOk_q;
    assign frame_err = frameErr_q;

`ifdef SPI_CRC_ERRCNT_EN
    logic [ERRCNT_W-1:0] errCnt_q, errCnt_d;

    // Saturates rather than wrapping so a flood of bad frames stays visible.
    always_comb begin
        errCnt_d = errCnt_q;
        if ((state_q == CHECK) && !crcOkNow && (errCnt_q != '1)) begin
            errCnt_d = errCnt_q + ERRCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            errCnt_q <= '0;
        end else begin
            errCnt_q <= errCnt_d;
        end
    end

    assign err_cnt = errCnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule
